// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer for a handshaked, variable-latency data memory.
// Optional request timeout/abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  // EX/MEM side
  input  logic              ex_valid,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  // data memory side
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  // pipeline control
  output logic              stall,
  output logic              wb_load_en,
  output logic [DATA_W-1:0] rdata_q,
  output logic              dm_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("dmem_access_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              access;
  logic              timeout;

  assign access = ex_valid & (ex_mem_rd | ex_mem_wr);

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_d, err_q;

  // Saturating count so a late grant that moves REQ->WAIT still times out in WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if ((state_q == StReq || state_q == StWait) && cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign timeout = (state_q == StReq || state_q == StWait) && (cnt_d == CntMax);
  assign err_d   = timeout & (((state_q == StReq) & ~dm_gnt) |
                              ((state_q == StWait) & ~dm_rvalid));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign dm_err = err_q;
`else
  assign timeout = 1'b0;
  assign dm_err  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    stall      = 1'b0;
    wb_load_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          stall   = 1'b1;
          state_d = StReq;
          req_d   = 1'b1;
          we_d    = ex_mem_wr;  // rd and wr together behave as a store
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
        end else begin
          wb_load_en = 1'b1;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (dm_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = StDone;
          end else if (dm_rvalid) begin
            state_d = StDone;
            rdata_d = dm_rdata;
          end else begin
            state_d = StWait;
          end
        end else if (timeout) begin
          req_d   = 1'b0;
          rdata_d = '0;
          state_d = StDone;
        end
      end
      StWait: begin
        stall = 1'b1;
        if (dm_rvalid) begin
          rdata_d = dm_rdata;
          state_d = StDone;
        end else if (timeout) begin
          rdata_d = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        // MEM/WB captures here; the next access is only evaluated back in IDLE.
        wb_load_en = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: driver pushes expected per-instruction results,
// a negedge monitor pops and compares when MEM/WB capture is enabled.
module tb_dmem_access_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid = 1'b0, ex_mem_rd = 1'b0, ex_mem_wr = 1'b0;
  logic [AW-1:0] ex_addr = '0;
  logic [DW-1:0] ex_wdata = '0;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt = 1'b0, dm_rvalid = 1'b0;
  logic [DW-1:0] dm_rdata = '0;
  logic          stall, wb_load_en, dm_err;
  logic [DW-1:0] rdata_q;

  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .ex_mem_rd (ex_mem_rd),
    .ex_mem_wr (ex_mem_wr),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .stall     (stall),
    .wb_load_en(wb_load_en),
    .rdata_q   (rdata_q),
    .dm_err    (dm_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          stall_n;
    int          req_n;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pop_cnt = 0;
  bit   mon_en = 1'b0;
  int   cyc_n = 0, stall_n = 0, req_n = 0;

  // memory responder configuration (gnt_dly 0 = never grant)
  int          m_gnt_dly = 0, m_rv_dly = 0;
  logic [31:0] m_rdata = '0;
  int          mem_req_n = 0, mem_rv_n = 0;
  bit          mem_granted = 1'b0, mem_rv_done = 1'b0, stale_rv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Responses driven on negedge, sampled by the DUT on the following posedge.
  always @(negedge clk) begin
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = 32'hA5A5_5A5A;
    if (stale_rv) begin
      dm_rvalid = 1'b1;
      dm_rdata  = 32'hFFFF_FFFF;
      stale_rv  = 1'b0;
    end else if (dm_req && !mem_granted) begin
      mem_req_n++;
      if (m_gnt_dly != 0 && mem_req_n == m_gnt_dly) begin
        dm_gnt      = 1'b1;
        mem_granted = 1'b1;
        mem_rv_n    = 0;
        if (!dm_we && m_rv_dly == 0) begin
          dm_rvalid   = 1'b1;
          dm_rdata    = m_rdata;
          mem_rv_done = 1'b1;
        end
      end
    end else if (mem_granted && !dm_we && !mem_rv_done) begin
      mem_rv_n++;
      if (mem_rv_n == m_rv_dly) begin
        dm_rvalid   = 1'b1;
        dm_rdata    = m_rdata;
        mem_rv_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && ex_valid && exp_q.size() != 0) begin
      mon_e = exp_q[0];
      cyc_n++;
      if (stall) stall_n++;
      if (dm_req) begin
        req_n++;
        check("req_addr", dm_addr, mon_e.addr);
        check("req_wdata", dm_wdata, mon_e.wdata);
        check("req_we", 32'(dm_we), 32'(mon_e.we));
      end
      if (wb_load_en) begin
        check("latency", cyc_n, mon_e.lat);
        check("stall_cycles", stall_n, mon_e.stall_n);
        check("req_cycles", req_n, mon_e.req_n);
        check("rdata_q", rdata_q, mon_e.rdata);
        check("dm_err", 32'(dm_err), 32'(mon_e.err));
        void'(exp_q.pop_front());
        cyc_n   = 0;
        stall_n = 0;
        req_n   = 0;
        pop_cnt++;
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                       input logic [31:0] mdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input int stall_c, input int req_c);
    exp_t e;
    int   target;
    e.addr = addr;  e.wdata = wdata;  e.we = wr;  e.rdata = exp_rdata;
    e.err  = exp_err;  e.lat = lat;  e.stall_n = stall_c;  e.req_n = req_c;
    m_gnt_dly = gnt_dly;  m_rv_dly = rv_dly;  m_rdata = mdata;
    mem_req_n = 0;  mem_rv_n = 0;  mem_granted = 1'b0;  mem_rv_done = 1'b0;
    exp_q.push_back(e);
    target    = pop_cnt + 1;
    ex_valid  = 1'b1;  ex_mem_rd = rd;  ex_mem_wr = wr;  ex_addr = addr;  ex_wdata = wdata;
    mon_en    = 1'b1;
    for (int i = 0; i < 100 && pop_cnt < target; i++) begin
      @(posedge clk);
      #1;
    end
    if (pop_cnt < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL completion_timeout: addr 0x%08h got no wb_load_en, required within 100 cycles",
               addr);
      exp_q.delete();
      cyc_n = 0;  stall_n = 0;  req_n = 0;
    end
    ex_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required $finish before 1ms");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_rdata_q", rdata_q, 32'd0);
    check("rst_dm_err", 32'(dm_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_load_en", 32'(wb_load_en), 32'd1);
    @(posedge clk);
    #1;

    // Reset while WAITing, then a stale rvalid must be ignored.
    m_gnt_dly = 1;  m_rv_dly = 100;  m_rdata = 32'h1111_1111;
    mem_req_n = 0;  mem_rv_n = 0;  mem_granted = 1'b0;  mem_rv_done = 1'b0;
    ex_valid = 1'b1;  ex_mem_rd = 1'b1;  ex_mem_wr = 1'b0;  ex_addr = 32'h400;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("wait_stall", 32'(stall), 32'd1);
    check("wait_dm_req", 32'(dm_req), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;  ex_valid = 1'b0;  ex_mem_rd = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    stale_rv = 1'b1;
    @(negedge clk);
    check("post_rst_dm_req", 32'(dm_req), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_wb_load_en", 32'(wb_load_en), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stale_rvalid_rdata_q", rdata_q, 32'd0);
    check("stale_rvalid_dm_req", 32'(dm_req), 32'd0);
    @(posedge clk);
    #1;

    //    rd    wr    addr    wdata          gnt rv  mdata          exp_rdata      err lat st rq
    issue(1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, 3, 0, 32'h0,         32'h0,         1'b0, 5, 4, 3);
    issue(1'b1, 1'b0, 32'h200, 32'h0,         1, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 6, 5, 1);
    issue(1'b1, 1'b0, 32'h300, 32'h0,         1, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 3, 2, 1);
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 1'b0, 32'h10 + 32'(i), 32'h55 + 32'(i), 0, 0, 32'h0, 32'h1234_5678,
            1'b0, 1, 0, 0);
    end
    issue(1'b1, 1'b1, 32'h500, 32'h0BAD_CAFE, 1, 0, 32'h7777_7777, 32'h1234_5678, 1'b0, 3, 2, 1);
    issue(1'b1, 1'b0, 32'h604, 32'h0,         2, 1, 32'h1357_2468, 32'h1357_2468, 1'b0, 5, 4, 2);

    // Memory op flags without ex_valid are not an access.
    ex_valid = 1'b0;  ex_mem_rd = 1'b1;  ex_mem_wr = 1'b1;
    @(negedge clk);
    check("novalid_stall", 32'(stall), 32'd0);
    check("novalid_wb_load_en", 32'(wb_load_en), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("novalid_dm_req", 32'(dm_req), 32'd0);
    @(posedge clk);
    #1;
    ex_mem_rd = 1'b0;  ex_mem_wr = 1'b0;

`ifdef DMEM_TIMEOUT_EN
    issue(1'b1, 1'b0, 32'h700, 32'h0, 0, 0, 32'h0,         32'h0,         1'b1, 6, 5, 4);
    issue(1'b1, 1'b0, 32'h704, 32'h0, 1, 0, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 3, 2, 1);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
